// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered NCH-channel, W-bit mux with manual select or round-robin auto scan
// Ports: clk, rst (sync, active-high); en (0 = no captures); mode (0 manual, 1 auto scan);
//        sel (manual channel); data_in (channel k = data_in[k*W +: W]); out_ready (downstream ready);
//        out_data/out_ch/out_valid (registered sample, its channel, valid); sel_err (sample from out-of-range sel).
// Optional: define MUX_SCAN_CH_MASK_EN to add ch_mask [NCH-1:0], restricting auto scan to enabled channels.
module mux_scan_reg #(
    parameter int NCH = 4,
    parameter int W = 8,
    parameter int DWELL = 2,
    localparam int SELW = $clog2(NCH)
) (
`ifdef MUX_SCAN_CH_MASK_EN
    input  logic [NCH-1:0]   ch_mask,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    input  logic [NCH*W-1:0] data_in,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_ch,
    output logic             out_valid,
    output logic             sel_err
);
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, MAN, AUTO} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic            sel_err_q, sel_err_d;

    logic            accept, entering, any, sel_bad;
    logic [SELW-1:0] eff_ch, cand;
    logic [DW-1:0]   eff_dwell;
    logic [W-1:0]    man_data, auto_data;

    always_comb begin
        int idx;
        idx = 0;
        // The state for this cycle follows en/mode directly; state_q only detects entry into AUTO.
        state_d = !en ? IDLE : (mode ? AUTO : MAN);
        accept = !out_valid_q || out_ready;
        entering = state_d == AUTO && state_q != AUTO;
        eff_ch = entering ? '0 : ch_q;
        eff_dwell = entering ? '0 : dwell_q;
        sel_bad = int'(sel) >= NCH;
        cand = eff_ch;
        any = 1'b1;
`ifdef MUX_SCAN_CH_MASK_EN
        // First enabled channel at or after eff_ch (wrapping); a now-masked ch_cnt is skipped.
        any = |ch_mask;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = int'(eff_ch) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (ch_mask[SELW'(idx)]) cand = SELW'(idx);
        end
`endif
        man_data = '0;
        auto_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) man_data = data_in[k*W +: W];
            if (cand == SELW'(k)) auto_data = data_in[k*W +: W];
        end
        ch_d = ch_q;
        dwell_d = dwell_q;
        out_data_d = out_data_q;
        out_ch_d = out_ch_q;
        sel_err_d = sel_err_q;
        out_valid_d = out_valid_q && !out_ready;
        if (state_d == AUTO) begin
            ch_d = eff_ch;
            dwell_d = eff_dwell != '0 ? eff_dwell - DW'(1) : eff_dwell;
        end
        if (state_d == MAN && accept) begin
            out_data_d = man_data;
            out_ch_d = sel;
            sel_err_d = sel_bad;
            out_valid_d = 1'b1;
        end
        if (state_d == AUTO && eff_dwell == '0 && any && accept) begin
            out_data_d = auto_data;
            out_ch_d = cand;
            sel_err_d = 1'b0;
            out_valid_d = 1'b1;
            ch_d = cand == SELW'(NCH - 1) ? '0 : cand + SELW'(1);
            dwell_d = DW'(DWELL - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q <= '0;
            dwell_q <= '0;
            out_data_q <= '0;
            out_ch_q <= '0;
            out_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q <= ch_d;
            dwell_q <= dwell_d;
            out_data_q <= out_data_d;
            out_ch_q <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ch = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err = sel_err_q;
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed stimulus with scoreboard queue and handshake monitor for mux_scan_reg
module tb_mux_scan_reg;
    logic        clk = 1'b0;
    logic        rst, en, mode, out_ready, out_valid, sel_err;
    logic [1:0]  sel, out_ch;
    logic [31:0] data_in;
    logic [7:0]  out_data;
`ifdef MUX_SCAN_CH_MASK_EN
    logic [3:0]  ch_mask;
`endif
    logic [10:0] q[$];
    int checks = 0;
    int errors = 0;

    mux_scan_reg #(.NCH(4), .W(8), .DWELL(2)) dut (
`ifdef MUX_SCAN_CH_MASK_EN
        .ch_mask(ch_mask),
`endif
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .data_in(data_in),
        .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] c);
        q.push_back({d, c, 1'b0});
    endtask

    // Every presented transfer must match the oldest expected sample.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got %0h ch %0d with nothing expected", out_data, out_ch);
            end else begin
                chk("sb_sample", {out_data, out_ch, sel_err}, q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; en = 0; mode = 0; sel = 0; out_ready = 0; data_in = 32'hDDCC_BBAA;
`ifdef MUX_SCAN_CH_MASK_EN
        ch_mask = 4'b1111;
`endif
        tick(1);
        chk("rst_out0", {out_data, out_ch, out_valid, sel_err}, 0);
        tick(1);
        chk("rst_out1", {out_data, out_ch, out_valid, sel_err}, 0);
        // manual select of channel 2
        rst = 0; en = 1; sel = 2; out_ready = 1;
        push(8'hCC, 2);
        tick(1);
        chk("man_valid", out_valid, 1);
        chk("man_data", {out_data, out_ch}, {8'hCC, 2'd2});
        en = 0;
        tick(1);
        chk("man_drain", out_valid, 0);
        // backpressure holds the first capture while sel moves
        en = 1; out_ready = 0; sel = 0;
        push(8'hAA, 0);
        tick(1);
        for (int i = 1; i <= 4; i++) begin
            sel = (i > 3) ? 2'd3 : 2'(i);
            tick(1);
            chk("bp_hold", {out_valid, out_data, out_ch}, {1'b1, 8'hAA, 2'd0});
        end
        out_ready = 1; sel = 3;
        push(8'hDD, 3);
        tick(1);
        chk("bp_release", {out_valid, out_data}, {1'b1, 8'hDD});
        en = 0;
        tick(1);
        chk("bp_drain", out_valid, 0);
        // auto scan, one sample every two cycles starting at channel 0
        en = 1; mode = 1; out_ready = 1;
        push(8'hAA, 0); push(8'hBB, 1); push(8'hCC, 2); push(8'hDD, 3); push(8'hAA, 0); push(8'hBB, 1);
        for (int i = 0; i <= 10; i++) begin
            tick(1);
            chk("auto_valid", out_valid, (i % 2) == 0);
            if (i % 2 == 0) chk("auto_ch", out_ch, (i / 2) % 4);
        end
        // stall while channel 2 is due: nothing skipped
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("stall_hold", {out_valid, out_ch}, {1'b1, 2'd1});
        end
        out_ready = 1;
        push(8'hCC, 2);
        tick(1);
        chk("stall_ch2", {out_valid, out_ch, out_data}, {1'b1, 2'd2, 8'hCC});
        tick(1);
        chk("stall_gap", out_valid, 0);
        out_ready = 0;
        tick(1);
        chk("stall_ch3", {out_valid, out_ch, out_data}, {1'b1, 2'd3, 8'hDD});
        // reset drops the pending sample
        rst = 1;
        tick(1);
        chk("midrst", {out_valid, out_ch, out_data}, 0);
        // en=0 holds a pending sample until taken, then stays idle
        rst = 0; en = 1; mode = 0; sel = 1; out_ready = 0;
        push(8'hBB, 1);
        tick(1);
        en = 0; sel = 3;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("idle_hold", {out_valid, out_data}, {1'b1, 8'hBB});
        end
        out_ready = 1;
        tick(1);
        chk("idle_taken", out_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("idle_quiet", out_valid, 0);
        end
`ifdef MUX_SCAN_CH_MASK_EN
        ch_mask = 4'b1010; en = 1; mode = 1; out_ready = 1;
        push(8'hBB, 1); push(8'hDD, 3); push(8'hBB, 1); push(8'hDD, 3);
        for (int i = 0; i <= 6; i++) begin
            tick(1);
            chk("mask_valid", out_valid, (i % 2) == 0);
            if (i % 2 == 0) chk("mask_ch", out_ch, (i % 4 == 0) ? 1 : 3);
        end
        ch_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("mask_none", out_valid, 0);
        end
`endif
        tick(2);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
Parametrised registered N-channel, W-bit multiplexer. It is the successor to the fixed 4:1 single-bit combinational mux.
- Manual mode: external select picks the channel.
- Auto mode: internal round-robin scanner steps through channels with a programmable dwell.
- Output is a registered valid/ready stage that feeds downstream sample consumers (display/serialiser blocks).

Parameters:
NCH, 4, number of input channels (>=2)
W, 8, data width per channel (>=1)
DWELL, 2, auto mode: cycles between emitted samples (>=1)
SELW, $clog2(NCH), select/channel index width (localparam-derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  block enable; 0 = no new captures
mode  input  1  0 = manual select, 1 = auto round-robin scan
sel  input  SELW  manual channel select
data_in  input  NCH*W  packed channels; channel k = data_in[k*W +: W]
out_ready  input  1  downstream ready
out_data  output  W  registered selected sample
out_ch  output  SELW  channel index of out_data
out_valid  output  1  out_data/out_ch valid
sel_err  output  1  1 when the held sample came from an out-of-range sel

Behaviour:
- Reset (rst=1 at posedge): out_data=0, out_ch=0, out_valid=0, sel_err=0, state=IDLE, ch_cnt=0, dwell_cnt=0. Reset overrides every other input in the same cycle, including mid-transfer; a pending sample is dropped.
- accept = !out_valid || out_ready. A capture happens only when accept=1. While out_valid=1 and out_ready=0, out_data/out_ch/sel_err are held stable.
- Handshake: a transfer completes on a cycle with out_valid && out_ready. If no new capture occurs that cycle, out_valid drops to 0 next cycle.
- Latency: data_in and sel sampled at posedge N appear on out_data after posedge N (1 cycle).
- FSM states: IDLE, MAN, AUTO. Transitions are evaluated every cycle:
  - en=0 -> IDLE.
  - en=1, mode=0 -> MAN.
  - en=1, mode=1 -> AUTO.
- IDLE: no captures. Pending out_valid is held until taken, never dropped.
- MAN: on each accept cycle, capture data_in[sel] and set out_ch=sel, out_valid=1, sel_err=0.
  - If sel >= NCH: out_data=0, out_ch=sel, sel_err=1.
- Entering AUTO from any other state: ch_cnt=0, dwell_cnt=0, so the first sample is emitted on the first AUTO cycle with accept=1.
- AUTO, per cycle:
  - If dwell_cnt!=0: dwell_cnt decrements.
  - If dwell_cnt==0 and accept=1: capture data_in[ch_cnt]; out_ch=ch_cnt, out_valid=1, sel_err=0; ch_cnt advances (NCH-1 wraps to 0); dwell_cnt reloads DWELL-1.
  - If dwell_cnt==0 and accept=0: stall; ch_cnt and dwell_cnt hold. No channel is skipped.
- DWELL=1: one sample per cycle under continuous out_ready=1.
- Mode change mid-scan takes effect next cycle. AUTO->MAN->AUTO restarts the scan at channel 0.
- sel is ignored in AUTO. data_in is never latched except on a capture.

Optional Feature:
Macro: MUX_SCAN_CH_MASK_EN.
- Defined:
  - Adds input ch_mask [NCH-1:0]; 1 = channel enabled.
  - AUTO captures only enabled channels. After a capture, ch_cnt moves to the next enabled channel above the current one, wrapping.
  - Entering AUTO starts at the lowest enabled channel.
  - If ch_mask==0: no captures, ch_cnt and dwell_cnt hold, and a pending out_valid is still held until taken.
  - If ch_mask changes mid-scan, it applies at the next channel advance. The current ch_cnt is re-evaluated: if it is now masked, it is skipped without emitting.
  - MAN mode is unaffected by ch_mask.
- Undefined: port absent; all channels scanned.

Test Plan:
1. Reset, manual selection: rst=1 for 2 cycles, then en=1, mode=0, out_ready=1, data_in={8'hDD,8'hCC,8'hBB,8'hAA}, sel=2 -> one cycle later out_data=8'hCC, out_ch=2, out_valid=1; all outputs 0 during reset.
2. Backpressure: MAN, out_ready=0, sel changes 0->3 over 5 cycles -> out_data stays at the first captured value (8'hAA) with out_valid=1. out_ready=1 -> next cycle out_data=8'hDD.
3. Auto scan: mode=1, DWELL=2, out_ready=1 -> out_ch sequence 0,1,2,3,0 with one new sample every 2 cycles; first sample on the cycle after entering AUTO.
4. Auto stall: AUTO, out_ready=0 for 4 cycles while ch_cnt=2 is due -> no skip; after release out_ch=2 then 3.
5. Mid-operation reset and enable: assert rst during AUTO with out_valid=1 -> next cycle out_valid=0, out_ch=0. Separately, en=0 with a pending sample -> sample held until out_ready, then out_valid=0 and no further captures.
6. Mask (MUX_SCAN_CH_MASK_EN): ch_mask=4'b1010 in AUTO -> out_ch sequence 1,3,1,3. ch_mask=0 -> out_valid falls after the last transfer and stays 0.
